spike_rate_decoder: RTL and testbench
=====================================

Name: spike_rate_decoder

Overview:
Downstream consumer of the three-input LIF network. It counts spikes from the three input neurons and the output neuron over a fixed window of clock cycles, then publishes the per-channel counts and the index of the most active input neuron. Results leave through a valid/ready handshake with one result register and a sticky overrun flag. This turns spike trains into rate-coded values for readout logic or an I/O shim.

Parameters:
WINDOW, 16, number of sampled clock cycles per counting window (legal range 2..256)
CNT_W, 5, width of each spike counter; counters saturate at 2^CNT_W-1

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous active-low reset
enable  input  1  level; 1 = run counting windows back to back, 0 = abort and idle
spike_1  input  1  spike from input neuron 1 (channel 0)
spike_2  input  1  spike from input neuron 2 (channel 1)
spike_3  input  1  spike from input neuron 3 (channel 2)
spike_output  input  1  spike from output neuron (channel 3)
result_ready  input  1  consumer accepts the result when high with result_valid
result_valid  output  1  result registers hold an unconsumed result
count_1  output  CNT_W  latched window count, channel 0
count_2  output  CNT_W  latched window count, channel 1
count_3  output  CNT_W  latched window count, channel 2
count_out  output  CNT_W  latched window count, channel 3
winner  output  2  0..2 = most active input channel; 3 = no input spikes in window
overrun  output  1  sticky; a completed window overwrote an unconsumed result
busy  output  1  high while in COUNT state

Behaviour:
- Reset: async, active-low. All outputs 0, state IDLE, working counters 0, window counter 0.
- FSM, 2 states:
  - IDLE: working counters and window counter held at 0. enable=1 -> COUNT at next edge. Spikes are not sampled in IDLE.
  - COUNT: busy=1. Each edge samples all four spike inputs. Each working counter increments on its spike and saturates at 2^CNT_W-1 with no wrap. The window counter increments 0..WINDOW-1.
- Window end: the edge where the window counter = WINDOW-1.
  - Latch the working counts into count_*, including spikes sampled on that edge.
  - Compute winner from those final counts.
  - Set result_valid=1.
  - Clear the working and window counters, stay in COUNT.
  - The next window starts sampling at the following edge. There is no dead cycle between windows.
- Result latency: result_valid rises exactly WINDOW edges after the first COUNT edge.
- Winner: maximum of channels 0..2 using unsigned compare of the saturated counts.
  - Ties go to the lowest index.
  - All three counts zero -> winner=3.
  - Channel 3 never takes part in the winner compare.
- Handshake:
  - result_valid and result_ready both high at an edge: the result is consumed and result_valid clears next cycle.
  - Output registers keep their values after consumption.
  - count_*/winner are stable while result_valid=1, except on overwrite.
- Simultaneous window end and accept at the same edge: the new result loads, result_valid stays 1, overrun unchanged.
- Window end with result_valid=1 and result_ready=0: the new result overwrites, result_valid stays 1, overrun is set to 1.
- overrun clears only on reset.
- enable=0 while in COUNT: the partial window is discarded at the next edge.
  - Working and window counters clear and the state returns to IDLE.
  - Latched results, result_valid and overrun are unaffected.
  - The handshake keeps working in IDLE.
- enable=0 on the window-end edge: the window completes and publishes, then the block enters IDLE.
- Reset mid-window: every register clears immediately. No result is produced.
- Spike inputs are synchronous to clk; the block adds no synchronisers.
- Window counter width is ceil(log2(WINDOW)).

Test Plan:
- Reset: hold reset=0 with random spikes and enable=1 -> all outputs 0. Release with enable=0 -> busy=0, no result_valid.
- Basic rates (WINDOW=8, CNT_W=5): spike_1 every cycle, spike_2 every other cycle, spike_3=0, spike_output on 3 cycles, result_ready=1 -> result_valid pulses 1 cycle after 8 COUNT edges, counts 8/4/0/3, winner=0. The next window follows with no gap.
- Saturation and ties (WINDOW=32, CNT_W=4):
  - All four spikes high for the whole window -> every count = 15, winner=0.
  - Second window, pattern giving counts 3/5/5 -> winner=1.
  - All inputs quiet -> winner=3.
- Backpressure (WINDOW=8): result_ready=0 across two windows with counts 2/0/0 then 0/6/0 -> second window shows 0/6/0, winner=1, overrun=1. Raise result_ready -> result_valid clears, overrun stays 1.
- Accept on window-end edge: result_ready pulses exactly on a window-end edge while result_valid=1 -> new counts loaded, result_valid stays 1, overrun stays 0.
- Abort:
  - enable drops after 5 COUNT cycles -> no new result, IDLE next edge. Re-enable with spike_3 every cycle -> full fresh window, counts 0/0/8/0, winner=2.
  - Assert reset at cycle 4 of a window -> all registers 0 at once.

Source files
------------

// File: rtl/spike_rate_decoder.sv
// Spike-rate decoder: counts spikes on three input channels and the output neuron over a
// fixed window of clock cycles, then publishes the counts and the most active input via valid/ready.
module spike_rate_decoder #(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             spike_1,
    input  logic             spike_2,
    input  logic             spike_3,
    input  logic             spike_output,
    input  logic             result_ready,
    output logic             result_valid,
    output logic [CNT_W-1:0] count_1,
    output logic [CNT_W-1:0] count_2,
    output logic [CNT_W-1:0] count_3,
    output logic [CNT_W-1:0] count_out,
    output logic [1:0]       winner,
    output logic             overrun,
    output logic             busy
);

    localparam int               WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [WIN_W-1:0]      win_cnt;
    logic [WIN_W-1:0]      win_cnt_nxt;
    logic [3:0][CNT_W-1:0] work_cnt;
    logic [3:0][CNT_W-1:0] work_nxt;
    logic [3:0][CNT_W-1:0] final_cnt;
    logic [3:0]            spikes;
    logic                  win_end;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic             hit);
        if (hit && (cnt != CNT_MAX)) begin
            return cnt + CNT_W'(1);
        end
        return cnt;
    endfunction

    // Strict greater-than keeps ties on the lowest index; an all-zero window reports 3.
    function automatic logic [1:0] pick_winner(input logic [CNT_W-1:0] c0,
                                               input logic [CNT_W-1:0] c1,
                                               input logic [CNT_W-1:0] c2);
        logic [1:0]       idx;
        logic [CNT_W-1:0] best;
        idx  = 2'd0;
        best = c0;
        if (c1 > best) begin
            idx  = 2'd1;
            best = c1;
        end
        if (c2 > best) begin
            idx  = 2'd2;
            best = c2;
        end
        if (best == '0) begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    assign spikes = {spike_output, spike_3, spike_2, spike_1};
    assign busy   = (state == COUNT);

    always_comb begin
        for (int ch = 0; ch < 4; ch++) begin
            final_cnt[ch] = sat_inc(work_cnt[ch], spikes[ch]);
        end
    end

    always_comb begin
        state_nxt   = state;
        win_end     = 1'b0;
        win_cnt_nxt = '0;
        work_nxt    = '0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = COUNT;
                end
            end
            COUNT: begin
                win_end = (win_cnt == WIN_LAST);
                // Dropping enable discards the partial window, but a window ending on
                // this edge still publishes through win_end.
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (!win_end) begin
                    win_cnt_nxt = win_cnt + WIN_W'(1);
                    work_nxt    = final_cnt;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            win_cnt  <= '0;
            work_cnt <= '0;
        end else begin
            state    <= state_nxt;
            win_cnt  <= win_cnt_nxt;
            work_cnt <= work_nxt;
        end
    end

    // Result register: a window end always loads; overrun marks an unconsumed result lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_valid <= 1'b0;
            overrun      <= 1'b0;
            count_1      <= '0;
            count_2      <= '0;
            count_3      <= '0;
            count_out    <= '0;
            winner       <= 2'd0;
        end else if (win_end) begin
            count_1      <= final_cnt[0];
            count_2      <= final_cnt[1];
            count_3      <= final_cnt[2];
            count_out    <= final_cnt[3];
            winner       <= pick_winner(final_cnt[0], final_cnt[1], final_cnt[2]);
            result_valid <= 1'b1;
            if (result_valid && !result_ready) begin
                overrun <= 1'b1;
            end
        end else if (result_valid && result_ready) begin
            result_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: two instances (8-cycle/5-bit and 32-cycle/4-bit) share stimulus
// and are compared every cycle against a window-level model, plus literal spot checks.
module tb_spike_rate_decoder;

    localparam int WA = 8;
    localparam int CA = 5;
    localparam int WB = 32;
    localparam int CB = 4;

    logic clk;
    logic reset;
    logic enable;
    logic spike_1, spike_2, spike_3, spike_output;
    logic result_ready;

    logic          va, ova, bza;
    logic [1:0]    wa;
    logic [CA-1:0] a1, a2, a3, ao;
    logic          vb, ovb, bzb;
    logic [1:0]    wb;
    logic [CB-1:0] b1, b2, b3, bo;

    spike_rate_decoder #(.WINDOW(WA), .CNT_W(CA)) dut_a (
        .clk(clk), .reset(reset), .enable(enable),
        .spike_1(spike_1), .spike_2(spike_2), .spike_3(spike_3), .spike_output(spike_output),
        .result_ready(result_ready), .result_valid(va),
        .count_1(a1), .count_2(a2), .count_3(a3), .count_out(ao),
        .winner(wa), .overrun(ova), .busy(bza)
    );

    spike_rate_decoder #(.WINDOW(WB), .CNT_W(CB)) dut_b (
        .clk(clk), .reset(reset), .enable(enable),
        .spike_1(spike_1), .spike_2(spike_2), .spike_3(spike_3), .spike_output(spike_output),
        .result_ready(result_ready), .result_valid(vb),
        .count_1(b1), .count_2(b2), .count_3(b3), .count_out(bo),
        .winner(wb), .overrun(ovb), .busy(bzb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Window-level model: sum raw spikes per window, clamp only when publishing.
    bit m_active[2];
    bit m_valid[2];
    bit m_ovr[2];
    int m_n[2];
    int m_sum[2][4];
    int m_out[2][4];
    int m_win[2];

    function automatic int wlen(int i);
        return (i == 0) ? WA : WB;
    endfunction

    function automatic int cmax(int i);
        return (i == 0) ? ((1 << CA) - 1) : ((1 << CB) - 1);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 0;
            m_valid[i]  = 0;
            m_ovr[i]    = 0;
            m_n[i]      = 0;
            m_win[i]    = 0;
            for (int ch = 0; ch < 4; ch++) begin
                m_sum[i][ch] = 0;
                m_out[i][ch] = 0;
            end
        end
    endtask

    task automatic model_step(int i);
        bit [3:0] sp;
        bit       accept;
        bit       done;
        int       best;
        sp     = {spike_output, spike_3, spike_2, spike_1};
        accept = m_valid[i] && result_ready;
        done   = 0;
        if (m_active[i]) begin
            for (int ch = 0; ch < 4; ch++) m_sum[i][ch] += int'(sp[ch]);
            m_n[i]++;
            if (m_n[i] == wlen(i)) begin
                done = 1;
                for (int ch = 0; ch < 4; ch++)
                    m_out[i][ch] = (m_sum[i][ch] > cmax(i)) ? cmax(i) : m_sum[i][ch];
                best = 0;
                for (int ch = 1; ch < 3; ch++)
                    if (m_out[i][ch] > m_out[i][best]) best = ch;
                m_win[i] = (m_out[i][best] == 0) ? 3 : best;
                if (m_valid[i] && !result_ready) m_ovr[i] = 1;
                m_valid[i] = 1;
                m_n[i]     = 0;
                for (int ch = 0; ch < 4; ch++) m_sum[i][ch] = 0;
            end
            if (!enable) begin
                m_active[i] = 0;
                m_n[i]      = 0;
                for (int ch = 0; ch < 4; ch++) m_sum[i][ch] = 0;
            end
        end else if (enable) begin
            m_active[i] = 1;
        end
        if (accept && !done) m_valid[i] = 0;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            model_clear();
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    task automatic cmp(int i, logic v, logic bz, logic ov, logic [1:0] w,
                       int c0, int c1, int c2, int c3);
        bit ok;
        ok = (v == m_valid[i]) && (bz == m_active[i]) && (ov == m_ovr[i]) &&
             (int'(w) == m_win[i]) && (c0 == m_out[i][0]) && (c1 == m_out[i][1]) &&
             (c2 == m_out[i][2]) && (c3 == m_out[i][3]);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL cycle_dut%0d t=%0t got v=%0b busy=%0b ovr=%0b win=%0d cnt=%0d/%0d/%0d/%0d want v=%0b busy=%0b ovr=%0b win=%0d cnt=%0d/%0d/%0d/%0d",
                     i, $time, v, bz, ov, w, c0, c1, c2, c3,
                     m_valid[i], m_active[i], m_ovr[i], m_win[i],
                     m_out[i][0], m_out[i][1], m_out[i][2], m_out[i][3]);
        end
    endtask

    always @(negedge clk) begin
        cmp(0, va, bza, ova, wa, int'(a1), int'(a2), int'(a3), int'(ao));
        cmp(1, vb, bzb, ovb, wb, int'(b1), int'(b2), int'(b3), int'(bo));
    end

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit s1, bit s2, bit s3, bit so);
        spike_1      = s1;
        spike_2      = s2;
        spike_3      = s3;
        spike_output = so;
        tick();
    endtask

    initial begin
        reset        = 1'b0;
        enable       = 1'b1;
        result_ready = 1'b0;
        spike_1      = 1'b0;
        spike_2      = 1'b0;
        spike_3      = 1'b0;
        spike_output = 1'b0;

        // Reset held with enable and random spikes
        repeat (4) begin
            {spike_1, spike_2, spike_3, spike_output} = 4'($urandom);
            tick();
        end
        chk("rst_outs_a", int'({va, bza, ova, wa, a1, a2, a3, ao}), 0);
        chk("rst_outs_b", int'({vb, bzb, ovb, wb, b1, b2, b3, bo}), 0);
        enable = 1'b0;
        reset  = 1'b1;
        drive(0, 0, 0, 0);
        chk("idle_busy", int'(bza), 0);
        chk("idle_valid", int'(va), 0);

        // Basic rates, two back-to-back windows
        result_ready = 1'b1;
        enable       = 1'b1;
        tick();
        chk("count_busy", int'(bza), 1);
        for (int k = 0; k < 16; k++) begin
            drive(1, (k % 2) == 0, 0, (k % 8) < 3);
            if (k == 6) chk("latency_early", int'(va), 0);
            if (k == 7) begin
                chk("basic_valid", int'(va), 1);
                chk("basic_c1", int'(a1), 8);
                chk("basic_c2", int'(a2), 4);
                chk("basic_c3", int'(a3), 0);
                chk("basic_co", int'(ao), 3);
                chk("basic_win", int'(wa), 0);
            end
            if (k == 8) chk("valid_pulse", int'(va), 0);
            if (k == 15) chk("no_gap_c1", int'(a1), 8);
        end
        chk("no_gap_valid", int'(va), 1);
        enable = 1'b0;
        drive(0, 0, 0, 0);
        chk("abort_idle", int'(bza), 0);

        // Saturation and ties on the 32-cycle, 4-bit instance
        enable = 1'b1;
        tick();
        for (int k = 0; k < 32; k++) drive(1, 1, 1, 1);
        chk("sat_valid", int'(vb), 1);
        chk("sat_c1", int'(b1), 15);
        chk("sat_c3", int'(b3), 15);
        chk("sat_co", int'(bo), 15);
        chk("sat_win", int'(wb), 0);
        for (int k = 0; k < 32; k++) drive(k < 3, k < 5, k < 5, 0);
        chk("tie_c1", int'(b1), 3);
        chk("tie_c2", int'(b2), 5);
        chk("tie_c3", int'(b3), 5);
        chk("tie_win", int'(wb), 1);
        for (int k = 0; k < 32; k++) drive(0, 0, 0, 0);
        chk("quiet_win", int'(wb), 3);
        chk("quiet_c2", int'(b2), 0);
        enable = 1'b0;
        tick();

        // Backpressure across two windows
        result_ready = 1'b0;
        enable       = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) drive(k < 2, 0, 0, 0);
        chk("bp1_c1", int'(a1), 2);
        chk("bp1_ovr", int'(ova), 0);
        for (int k = 0; k < 8; k++) drive(0, k < 6, 0, 0);
        chk("bp2_valid", int'(va), 1);
        chk("bp2_c1", int'(a1), 0);
        chk("bp2_c2", int'(a2), 6);
        chk("bp2_win", int'(wa), 1);
        chk("bp2_ovr", int'(ova), 1);
        result_ready = 1'b1;
        enable       = 1'b0;
        tick();
        chk("bp_drain_valid", int'(va), 0);
        chk("bp_sticky_ovr", int'(ova), 1);

        // Accept on the window-end edge
        reset = 1'b0;
        #1;
        reset = 1'b1;
        chk("rst_clears_ovr", int'(ova), 0);
        result_ready = 1'b0;
        enable       = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) drive(k == 0, 0, 0, 0);
        chk("acc1_c1", int'(a1), 1);
        for (int k = 0; k < 8; k++) begin
            result_ready = (k == 7);
            drive(0, 0, 1, 0);
        end
        chk("acc_valid", int'(va), 1);
        chk("acc_c3", int'(a3), 8);
        chk("acc_win", int'(wa), 2);
        chk("acc_ovr", int'(ova), 0);
        result_ready = 1'b1;
        enable       = 1'b0;
        tick();
        chk("acc_consumed", int'(va), 0);

        // Abort after 5 cycles, then fresh window ending with enable low
        enable = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) drive(1, 0, 0, 0);
        enable = 1'b0;
        drive(0, 0, 0, 0);
        chk("abort_busy", int'(bza), 0);
        chk("abort_valid", int'(va), 0);
        enable = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            if (k == 7) enable = 1'b0;
            drive(0, 0, 1, 0);
        end
        chk("fresh_valid", int'(va), 1);
        chk("fresh_c1", int'(a1), 0);
        chk("fresh_c3", int'(a3), 8);
        chk("fresh_win", int'(wa), 2);
        chk("end_then_idle", int'(bza), 0);

        // Reset in the middle of a window
        enable = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) drive(0, 1, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_a", int'({va, bza, ova, wa, a1, a2, a3, ao}), 0);
        chk("midrst_b", int'({vb, bzb, ovb, wb, b1, b2, b3, bo}), 0);
        tick();
        reset = 1'b1;
        enable = 1'b0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
